// File: rtl/kule_gfx_pkg.sv
// Shared graphics types and geometry for the sprite pipeline.
package kule_gfx_pkg;

    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int SPRITE_W  = 32;
    localparam int SPRITE_H  = 32;
    localparam int MAX_SCALE = 4;

    typedef logic [3:0] color_t;

    typedef struct packed {
        logic [7:0]         id;
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [7:0]         scale;
    } sprite_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_ADVANCE,
        ST_DONE
    } blit_state_t;

    // Zero magnification is treated as 1:1; anything above the limit saturates.
    function automatic logic [7:0] clamp_scale(input logic [7:0] s, input int max_s);
        if (s == 8'd0) return 8'd1;
        if (int'(s) > max_s) return 8'(max_s);
        return s;
    endfunction

endpackage

// File: rtl/blit_coord_walker.sv
// Raster walker over the scaled destination rectangle: source texel, destination
// offsets, framebuffer row base and last-pixel flag, stepped by one strobe.
module blit_coord_walker #(
    parameter int SPRITE_W  = 32,
    parameter int SPRITE_H  = 32,
    parameter int FB_W      = 320,
    parameter int MAX_SCALE = 4,
    parameter int SX_W      = $clog2(SPRITE_W),
    parameter int SY_W      = $clog2(SPRITE_H),
    parameter int DX_W      = $clog2(SPRITE_W * MAX_SCALE) + 1,
    parameter int DY_W      = $clog2(SPRITE_H * MAX_SCALE) + 1,
    parameter int SC_W      = $clog2(MAX_SCALE) + 1,
    parameter int RB_W      = 26
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   advance,
    input  logic [SC_W-1:0]        scale,
    input  logic signed [15:0]     y,
    output logic [SX_W-1:0]        src_x,
    output logic [SY_W-1:0]        src_y,
    output logic [DX_W-1:0]        dx,
    output logic [DY_W-1:0]        dy,
    output logic signed [RB_W-1:0] row_base,
    output logic                   last
);

    logic [SC_W-1:0] sub_x;
    logic [SC_W-1:0] sub_y;
    logic [DX_W-1:0] span_x;
    logic [DY_W-1:0] span_y;
    logic            row_end;
    logic            sub_x_end;
    logic            sub_y_end;

    assign span_x    = DX_W'(SPRITE_W) * DX_W'(scale);
    assign span_y    = DY_W'(SPRITE_H) * DY_W'(scale);
    assign row_end   = (dx == span_x - 1'b1);
    assign last      = row_end && (dy == span_y - 1'b1);
    assign sub_x_end = (sub_x == scale - 1'b1);
    assign sub_y_end = (sub_y == scale - 1'b1);

    always_ff @(posedge clock) begin
        if (reset) begin
            src_x    <= '0;
            src_y    <= '0;
            sub_x    <= '0;
            sub_y    <= '0;
            dx       <= '0;
            dy       <= '0;
            row_base <= '0;
        end else if (load) begin
            src_x    <= '0;
            src_y    <= '0;
            sub_x    <= '0;
            sub_y    <= '0;
            dx       <= '0;
            dy       <= '0;
            row_base <= RB_W'(y) * RB_W'(FB_W);
        end else if (advance) begin
            if (row_end) begin
                // End of a destination row: the source column restarts with it.
                dx       <= '0;
                sub_x    <= '0;
                src_x    <= '0;
                dy       <= dy + 1'b1;
                row_base <= row_base + RB_W'(FB_W);
                if (sub_y_end) begin
                    sub_y <= '0;
                    src_y <= src_y + 1'b1;
                end else begin
                    sub_y <= sub_y + 1'b1;
                end
            end else begin
                dx <= dx + 1'b1;
                if (sub_x_end) begin
                    sub_x <= '0;
                    src_x <= src_x + 1'b1;
                end else begin
                    sub_x <= sub_x + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Draws queued sprites into the framebuffer: scaled, clipped, colour 0 transparent.
// One source read per destination pixel; writes wait on the framebuffer handshake.
module sprite_blitter #(
    parameter int SPRITE_NUM       = 16,
    parameter int SPRITE_ADDR_SIZE = 9,
    parameter int SPRITE_W         = kule_gfx_pkg::SPRITE_W,
    parameter int SPRITE_H         = kule_gfx_pkg::SPRITE_H,
    parameter int FB_W             = kule_gfx_pkg::FB_W,
    parameter int FB_H             = kule_gfx_pkg::FB_H,
    parameter int MAX_SCALE        = kule_gfx_pkg::MAX_SCALE
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          is_empty,
    input  logic [7:0]                    sprite_id,
    input  logic [15:0]                   sprite_x,
    input  logic [15:0]                   sprite_y,
    input  logic [7:0]                    sprite_scale,
    output logic                          dequeue,
    output logic [$clog2(SPRITE_NUM)-1:0] sprite_r_select,
    output logic [SPRITE_ADDR_SIZE:0]     sprite_r_addr,
    input  logic [3:0]                    sprite_r_data,
    output logic                          fb_w_en,
    output logic [$clog2(FB_W*FB_H)-1:0]  fb_w_addr,
    output logic [3:0]                    fb_w_data,
    input  logic                          fb_w_ready,
    output logic                          busy,
    output logic                          sprite_done
);
    import kule_gfx_pkg::*;

    localparam int SEL_W  = $clog2(SPRITE_NUM);
    localparam int ADDR_W = SPRITE_ADDR_SIZE + 1;
    localparam int FBA_W  = $clog2(FB_W * FB_H);
    localparam int SX_W   = $clog2(SPRITE_W);
    localparam int SY_W   = $clog2(SPRITE_H);
    localparam int DX_W   = $clog2(SPRITE_W * MAX_SCALE) + 1;
    localparam int DY_W   = $clog2(SPRITE_H * MAX_SCALE) + 1;
    localparam int SC_W   = $clog2(MAX_SCALE) + 1;
    localparam int RB_W   = 26;

    blit_state_t            state;
    blit_state_t            state_next;
    sprite_cmd_t            cmd;
    color_t                 pixel;
    logic [SX_W-1:0]        src_x;
    logic [SY_W-1:0]        src_y;
    logic [DX_W-1:0]        dx;
    logic [DY_W-1:0]        dy;
    logic signed [RB_W-1:0] row_base;
    logic                   last;
    logic signed [16:0]     px;
    logic signed [16:0]     py;
    logic                   pix_visible;

    blit_coord_walker #(
        .SPRITE_W  (SPRITE_W),
        .SPRITE_H  (SPRITE_H),
        .FB_W      (FB_W),
        .MAX_SCALE (MAX_SCALE),
        .SX_W      (SX_W),
        .SY_W      (SY_W),
        .DX_W      (DX_W),
        .DY_W      (DY_W),
        .SC_W      (SC_W),
        .RB_W      (RB_W)
    ) u_walker (
        .clock    (clock),
        .reset    (reset),
        .load     (state == ST_LOAD),
        .advance  (state == ST_ADVANCE),
        .scale    (SC_W'(cmd.scale)),
        .y        (cmd.y),
        .src_x    (src_x),
        .src_y    (src_y),
        .dx       (dx),
        .dy       (dy),
        .row_base (row_base),
        .last     (last)
    );

    // Select and address come straight from registers, so they are valid throughout READ.
    assign sprite_r_select = SEL_W'(cmd.id);
    assign sprite_r_addr   = ADDR_W'({src_y, src_x});

    assign pixel       = sprite_r_data;
    assign px          = {cmd.x[15], cmd.x} + 17'(dx);
    assign py          = {cmd.y[15], cmd.y} + 17'(dy);
    assign pix_visible = (pixel != '0) && !px[16] && (px < 17'(FB_W))
                                       && !py[16] && (py < 17'(FB_H));

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (enable && !is_empty) state_next = ST_LOAD;
            ST_LOAD:    state_next = ST_READ;
            ST_READ:    state_next = ST_WAIT;
            ST_WAIT:    state_next = pix_visible ? ST_WRITE : ST_ADVANCE;
            ST_WRITE:   if (fb_w_ready) state_next = ST_ADVANCE;
            ST_ADVANCE: state_next = last ? ST_DONE : ST_READ;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Strobes are derived from the next state so every output leaves a flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cmd         <= '0;
            dequeue     <= 1'b0;
            busy        <= 1'b0;
            sprite_done <= 1'b0;
            fb_w_en     <= 1'b0;
            fb_w_addr   <= '0;
            fb_w_data   <= '0;
        end else begin
            state       <= state_next;
            dequeue     <= (state_next == ST_LOAD);
            busy        <= (state_next != ST_IDLE);
            sprite_done <= (state_next == ST_DONE);
            fb_w_en     <= (state_next == ST_WRITE);
            if (state == ST_IDLE && state_next == ST_LOAD) begin
                cmd.id    <= sprite_id;
                cmd.x     <= sprite_x;
                cmd.y     <= sprite_y;
                cmd.scale <= clamp_scale(sprite_scale, MAX_SCALE);
            end
            if (state == ST_WAIT && pix_visible) begin
                fb_w_addr <= FBA_W'(row_base + RB_W'(px));
                fb_w_data <= pixel;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a loop-based drawing model predicts every
// framebuffer write and the cycle count of each sprite.
module tb_sprite_blitter;

    localparam int FB_W = 320;
    localparam int FB_H = 240;
    localparam int SW   = 32;
    localparam int SH   = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        is_empty = 1'b1;
    logic [7:0]  sprite_id = '0;
    logic [15:0] sprite_x = '0;
    logic [15:0] sprite_y = '0;
    logic [7:0]  sprite_scale = '0;
    logic        dequeue;
    logic [3:0]  sprite_r_select;
    logic [9:0]  sprite_r_addr;
    logic [3:0]  sprite_r_data = '0;
    logic        fb_w_en;
    logic [16:0] fb_w_addr;
    logic [3:0]  fb_w_data;
    logic        fb_w_ready = 1'b1;
    logic        busy;
    logic        sprite_done;

    sprite_blitter #(
        .SPRITE_NUM       (16),
        .SPRITE_ADDR_SIZE (9),
        .SPRITE_W         (32),
        .SPRITE_H         (32),
        .FB_W             (320),
        .FB_H             (240),
        .MAX_SCALE        (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .is_empty        (is_empty),
        .sprite_id       (sprite_id),
        .sprite_x        (sprite_x),
        .sprite_y        (sprite_y),
        .sprite_scale    (sprite_scale),
        .dequeue         (dequeue),
        .sprite_r_select (sprite_r_select),
        .sprite_r_addr   (sprite_r_addr),
        .sprite_r_data   (sprite_r_data),
        .fb_w_en         (fb_w_en),
        .fb_w_addr       (fb_w_addr),
        .fb_w_data       (fb_w_data),
        .fb_w_ready      (fb_w_ready),
        .busy            (busy),
        .sprite_done     (sprite_done)
    );

    always #5 clock = ~clock;

    logic [3:0] mem [16][1024];
    always @(posedge clock) sprite_r_data <= mem[sprite_r_select][sprite_r_addr];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_addr[$];
    int exp_data[$];
    int exp_writes, exp_cycles;
    int wr_cnt, deq_cnt, done_cnt, busy_cnt;
    int first_addr, first_data, last_addr;
    logic [3:0] fb_act [FB_W*FB_H];

    // Every cycle with a write offered must match the next predicted write.
    always @(negedge clock) begin
        if (dequeue) deq_cnt++;
        if (sprite_done) done_cnt++;
        if (busy) busy_cnt++;
        if (fb_w_en) begin
            n_checks++;
            if (exp_addr.size() == 0) begin
                n_fail++;
                $display("FAIL fb_write: got addr %0d data %0d, required no write", fb_w_addr, fb_w_data);
            end else if (int'(fb_w_addr) != exp_addr[0] || int'(fb_w_data) != exp_data[0]) begin
                n_fail++;
                $display("FAIL fb_write: got addr %0d data %0d, required addr %0d data %0d",
                         fb_w_addr, fb_w_data, exp_addr[0], exp_data[0]);
            end
            if (fb_w_ready) begin
                if (exp_addr.size() != 0) begin
                    void'(exp_addr.pop_front());
                    void'(exp_data.pop_front());
                end
                if (wr_cnt == 0) begin
                    first_addr = int'(fb_w_addr);
                    first_data = int'(fb_w_data);
                end
                last_addr = int'(fb_w_addr);
                wr_cnt++;
                if (int'(fb_w_addr) < FB_W*FB_H) fb_act[fb_w_addr] = fb_w_data;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic build_expect(input int slot, input int x, input int y, input int scale, input int stall);
        int s;
        int c;
        int px;
        int py;
        s = (scale == 0) ? 1 : ((scale > 4) ? 4 : scale);
        exp_addr.delete();
        exp_data.delete();
        exp_cycles = 2 + stall;
        for (int ry = 0; ry < SH*s; ry++) begin
            for (int rx = 0; rx < SW*s; rx++) begin
                c  = int'(mem[slot][(ry/s)*SW + rx/s]);
                px = x + rx;
                py = y + ry;
                exp_cycles += 3;
                if (c != 0 && px >= 0 && px < FB_W && py >= 0 && py < FB_H) begin
                    exp_addr.push_back(py*FB_W + px);
                    exp_data.push_back(c);
                    exp_cycles += 1;
                end
            end
        end
        exp_writes = exp_addr.size();
    endtask

    task automatic load_cmd(input int slot, input int x, input int y, input int scale, input int stall);
        build_expect(slot, x, y, scale, stall);
        wr_cnt = 0; deq_cnt = 0; done_cnt = 0; busy_cnt = 0;
        first_addr = -1; first_data = -1; last_addr = -1;
        for (int i = 0; i < FB_W*FB_H; i++) fb_act[i] = '0;
        sprite_id    = 8'(slot);
        sprite_x     = 16'(x);
        sprite_y     = 16'(y);
        sprite_scale = 8'(scale);
        is_empty     = 1'b0;
    endtask

    task automatic finish_sprite(input string name, input bit stall);
        bit ok;
        bit stalled;
        ok = 1'b0;
        stalled = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (dequeue) begin ok = 1'b1; break; end
            step();
        end
        is_empty = 1'b1;
        check({name, " dequeue"}, int'(ok), 1);
        ok = 1'b0;
        for (int c = 0; c < 40000; c++) begin
            if (sprite_done) begin ok = 1'b1; break; end
            if (stall && !stalled && fb_w_en && wr_cnt == 2) begin
                stalled = 1'b1;
                fb_w_ready = 1'b0;
                repeat (5) step();
                fb_w_ready = 1'b1;
            end else begin
                step();
            end
        end
        check({name, " sprite_done seen"}, int'(ok), 1);
        step();
        check({name, " busy after done"}, int'(busy), 0);
        check({name, " done pulse width"}, int'(sprite_done), 0);
        check({name, " dequeue count"}, deq_cnt, 1);
        check({name, " done count"}, done_cnt, 1);
        check({name, " write count"}, wr_cnt, exp_writes);
        check({name, " busy cycles"}, busy_cnt, exp_cycles);
        check({name, " writes left"}, exp_addr.size(), 0);
    endtask

    initial begin
        for (int s = 0; s < 16; s++)
            for (int a = 0; a < 1024; a++) mem[s][a] = '0;
        for (int a = 0; a < 1024; a++) begin
            mem[2][a] = 4'd5;
            mem[3][a] = (((a % SW) + (a / SW)) % 2 == 1) ? 4'd2 : 4'd1;
        end
        mem[2][0] = 4'd0;

        repeat (3) step();
        check("reset dequeue", int'(dequeue), 0);
        check("reset fb_w_en", int'(fb_w_en), 0);
        check("reset busy", int'(busy), 0);
        check("reset sprite_done", int'(sprite_done), 0);
        check("reset select", int'(sprite_r_select), 0);
        check("reset r_addr", int'(sprite_r_addr), 0);
        check("reset fb_w_addr", int'(fb_w_addr), 0);
        check("reset fb_w_data", int'(fb_w_data), 0);
        reset = 1'b0;
        step();

        // Plain 1:1 sprite fully on screen.
        load_cmd(2, 10, 20, 1, 0);
        enable = 1'b1;
        finish_sprite("basic", 1'b0);
        check("basic writes literal", wr_cnt, 1023);
        check("basic first addr", first_addr, 6411);
        check("basic first data", first_data, 5);
        check("basic last addr", last_addr, 16361);
        check("basic cycles literal", busy_cnt, 4097);

        // Left clip; an extra transparent texel in the visible area.
        mem[2][31*SW + 31] = 4'd0;
        load_cmd(2, -4, 0, 1, 0);
        finish_sprite("left clip", 1'b0);
        check("left clip writes literal", wr_cnt, 895);
        check("left clip first addr", first_addr, 0);

        load_cmd(3, 0, 0, 2, 0);
        finish_sprite("scale2", 1'b0);
        check("scale2 writes literal", wr_cnt, 4096);
        check("scale2 dest(0,0)", int'(fb_act[0]), 1);
        check("scale2 dest(1,0)", int'(fb_act[1]), 1);
        check("scale2 dest(0,1)", int'(fb_act[320]), 1);
        check("scale2 dest(1,1)", int'(fb_act[321]), 1);
        check("scale2 dest(2,0)", int'(fb_act[2]), 2);

        load_cmd(3, 100, 100, 0, 0);
        finish_sprite("scale0", 1'b0);
        check("scale0 writes literal", wr_cnt, 1024);
        check("scale0 dest(100,100)", int'(fb_act[100*320+100]), 1);
        check("scale0 dest(101,100)", int'(fb_act[100*320+101]), 2);

        load_cmd(2, 10, 20, 1, 5);
        finish_sprite("stall", 1'b1);
        check("stall writes literal", wr_cnt, 1022);

        // Enable gating with a waiting entry.
        enable = 1'b0;
        load_cmd(2, 50, 60, 1, 0);
        repeat (5) step();
        check("gated dequeue count", deq_cnt, 0);
        check("gated busy", int'(busy), 0);
        enable = 1'b1;
        check("gated dequeue before edge", int'(dequeue), 0);
        step();
        check("gated dequeue second cycle", int'(dequeue), 1);
        finish_sprite("gated", 1'b0);

        // Oversized scale, aborted by reset partway through.
        load_cmd(3, 0, 0, 9, 0);
        for (int c = 0; c < 20 && !dequeue; c++) step();
        is_empty = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            if (wr_cnt >= 200) break;
            step();
        end
        check("scale9 progress", int'(wr_cnt >= 200), 1);
        check("scale9 dest(127,0)", int'(fb_act[127]), 2);
        check("scale9 dest(128,0)", int'(fb_act[128]), 0);
        check("scale9 dest(0,1)", int'(fb_act[320]), 1);
        reset = 1'b1;
        step();
        check("abort fb_w_en", int'(fb_w_en), 0);
        check("abort busy", int'(busy), 0);
        check("abort dequeue", int'(dequeue), 0);
        reset = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        step();

        load_cmd(2, 5, 5, 1, 0);
        finish_sprite("after abort", 1'b0);
        check("after abort first addr", first_addr, 5*320 + 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
